multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Next-generation control unit for the multi-cycle simpleCPU datapath; drives the same control bus (PC, IR, MDR, register file, ALU, flags) from the decoded opcode and the N/Z flags.
- Adds a memory ready handshake, so every memory state holds until mem_ready is high.
- Adds a parametrised bus-timeout fault state, a selectable illegal-opcode trap and a retired-instruction counter.
- Sits between IR[3:0] and the datapath; the memory model asserts mem_ready.

Parameters:
WAIT_MAX, 15, maximum consecutive not-ready cycles in one memory state before fault; 0 disables the timeout
WAIT_W, 4, width of wait counter; must hold WAIT_MAX
CNT_W, 16, width of retired_count
ILLEGAL_TRAP, 0, 0: illegal opcode returns to S_RESET; 1: illegal opcode enters S_FAULT

Ports:
clock input 1 system clock, rising edge
reset input 1 asynchronous, active-high
instr input 4 opcode field IR[3:0]
N input 1 negative flag
Z input 1 zero flag
mem_ready input 1 memory completes the access this cycle
PCwrite, MemRead, MemWrite, IRload, OpASel, MDRload, OpABLoad, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite output 1 each datapath controls
AddrSel output 2 address mux select
ALU2 output 3 ALU B-operand select
ALUop output 3 ALU operation
state output 5 current state encoding
mem_wait output 1 in a memory state with mem_ready=0
instr_done output 1 high in the last cycle of every instruction
fault output 1 high in S_FAULT
retired_count output CNT_W instructions completed, wraps

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; clock is clock. On reset: state=S_RESET(0), wait counter=0, retired_count=0.
- Outputs: combinational from state and inputs; all are 0 in S_RESET, S_FAULT and in any state not listed below.
- State encodings: C1=1, C2=2, C3_ASN=3, C4_ASNSH=4, C3_SHIFT=5, C3_ORI=6, C4_ORI=7, C5_ORI=8, C3_LOAD=9, C4_LOAD=10, C3_STORE=11, C3_BPZ=12, C3_BZ=13, C3_BNZ=14, C3_LDIND=15, C4_LDIND=16, C5_LDIND=17, C6_LDIND=18, S_FAULT=31.
- Decode in C2 (first match wins):
  - 0100/0110/1000 -> C3_ASN
  - instr[2:0]=011 -> C3_SHIFT
  - instr[2:0]=111 -> C3_ORI
  - 0000 -> C3_LOAD
  - 0010 -> C3_STORE
  - 1101 -> C3_BPZ
  - 0101 -> C3_BZ
  - 1001 -> C3_BNZ
  - 0001 -> C3_LDIND
  - else illegal, handled per ILLEGAL_TRAP
- Sequences:
  - S_RESET -> C1 -> C2
  - C3_ASN -> C4_ASNSH; C3_SHIFT -> C4_ASNSH; C4_ASNSH -> C1
  - C3_ORI -> C4_ORI -> C5_ORI -> C1
  - C3_LOAD -> C4_LOAD -> C1
  - C3_STORE, C3_BPZ, C3_BZ, C3_BNZ -> C1
  - C3_LDIND -> C4_LDIND -> C5_LDIND -> C6_LDIND -> C1
  - S_FAULT: absorbing until reset.
- Memory states are C1, C3_LOAD, C3_STORE, C3_LDIND and C5_LDIND:
  - The state advances only when mem_ready=1; otherwise it holds.
  - MemRead/MemWrite/AddrSel are held for the whole state.
  - PCwrite, IRload and MDRload are gated by mem_ready, so no register commits while waiting.
- Per-state outputs (unlisted = 0; rdy = mem_ready):
  - C1: PCwrite=rdy, AddrSel=01, MemRead=1, IRload=rdy, ALU2=001.
  - C2: OpABLoad=1.
  - C3_ASN: ALU1=1, ALUOutWrite=1, FlagWrite=1; ALUop=000 add, 001 sub, 011 nand.
  - C3_SHIFT: ALU1=1, ALU2=100, ALUop=100, ALUOutWrite=1, FlagWrite=1.
  - C4_ASNSH: RFWrite=1.
  - C3_ORI: OpASel=1, OpABLoad=1.
  - C4_ORI: ALU1=1, ALU2=011, ALUop=010, ALUOutWrite=1, FlagWrite=1.
  - C5_ORI: OpASel=1, RFWrite=1.
  - C3_LOAD, C3_LDIND: AddrSel=00, MemRead=1, MDRload=rdy.
  - C4_LOAD: ALUOutWrite=1, RFWrite=1, RegIn=1.
  - C3_STORE: MemWrite=1.
  - C3_BPZ/BZ/BNZ: ALU2=010; PCwrite = ~N / Z / ~Z respectively.
  - C4_LDIND: OpABLoad=1, RFWrite=1, RegIn=1.
  - C5_LDIND: AddrSel=10, MemRead=1, MDRload=rdy.
  - C6_LDIND: AddrSel=10, OpABLoad=1, RFWrite=1, RegIn=1.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in a memory state with mem_ready=0.
  - If WAIT_MAX>0 and the counter equals WAIT_MAX while mem_ready=0, the next state is S_FAULT. A fault is therefore entered after WAIT_MAX+1 not-ready cycles.
  - mem_ready=1 in that same cycle wins: normal advance.
- instr_done:
  - 1 in C4_ASNSH, C5_ORI, C4_LOAD, C6_LDIND and the branch states.
  - 1 in C3_STORE only when mem_ready=1.
- retired_count increments on each clock edge with instr_done=1 and wraps from all-ones to 0.
- Reset mid-instruction: immediate return to S_RESET; all outputs 0 in the same cycle.

Test Plan:
- ADD (0100), mem_ready tied 1 -> states 1,2,3,4,1; ALUop=000 in state 3; instr_done in state 4; retired_count 0->1.
- LDIND (0001), mem_ready low 3 cycles in C3_LDIND -> mem_wait=1 and MDRload=0 for 3 cycles; MDRload=1 on the ready cycle; then states 16,17,18,1; retired_count +1.
- BZ with Z=0, then BZ with Z=1 -> PCwrite=0 then 1 in state 13; ALU2=010 both times.
- WAIT_MAX=3, mem_ready stuck 0 in C1 -> state 31 after 4 wait cycles; fault=1; all controls 0; held until reset.
- ILLEGAL_TRAP=1, instr=1111? No: 1111 decodes as ORI. Use instr=1010 -> C2 goes to 31. With ILLEGAL_TRAP=0, instr=1010 -> C2 goes to 0, then 1.
- Reset asserted in C5_ORI, and retired_count at all-ones with one more instruction -> state=0 asynchronously; retired_count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Control unit for the multi-cycle simpleCPU datapath.
// Decodes IR[3:0] and the N/Z flags into the datapath control bus. Memory
// states wait for mem_ready, a stuck memory drives the unit into a fault
// state, and completed instructions are counted.
module multicycle_ctrl_fsm #(
    parameter int WAIT_MAX     = 15,
    parameter int WAIT_W       = 4,
    parameter int CNT_W        = 16,
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       instr,
    input  logic             N,
    input  logic             Z,
    input  logic             mem_ready,
    output logic             PCwrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRload,
    output logic             OpASel,
    output logic             MDRload,
    output logic             OpABLoad,
    output logic             ALU1,
    output logic             ALUOutWrite,
    output logic             RFWrite,
    output logic             RegIn,
    output logic             FlagWrite,
    output logic [1:0]       AddrSel,
    output logic [2:0]       ALU2,
    output logic [2:0]       ALUop,
    output logic [4:0]       state,
    output logic             mem_wait,
    output logic             instr_done,
    output logic             fault,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,  C1       = 5'd1,  C2       = 5'd2,  C3_ASN   = 5'd3,
        C4_ASNSH = 5'd4,  C3_SHIFT = 5'd5,  C3_ORI   = 5'd6,  C4_ORI   = 5'd7,
        C5_ORI   = 5'd8,  C3_LOAD  = 5'd9,  C4_LOAD  = 5'd10, C3_STORE = 5'd11,
        C3_BPZ   = 5'd12, C3_BZ    = 5'd13, C3_BNZ   = 5'd14, C3_LDIND = 5'd15,
        C4_LDIND = 5'd16, C5_LDIND = 5'd17, C6_LDIND = 5'd18, S_FAULT  = 5'd31
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    state_t            succ_s;
    logic [WAIT_W-1:0] wait_r;
    logic [CNT_W-1:0]  retired_r;
    logic              is_mem_s;
    logic              timeout_s;

    // Opcode decode used when leaving C2; first match wins.
    function automatic state_t decode(input logic [3:0] op);
        state_t d;
        if (op == 4'b0100 || op == 4'b0110 || op == 4'b1000) d = C3_ASN;
        else if (op[2:0] == 3'b011) d = C3_SHIFT;
        else if (op[2:0] == 3'b111) d = C3_ORI;
        else if (op == 4'b0000)     d = C3_LOAD;
        else if (op == 4'b0010)     d = C3_STORE;
        else if (op == 4'b1101)     d = C3_BPZ;
        else if (op == 4'b0101)     d = C3_BZ;
        else if (op == 4'b1001)     d = C3_BNZ;
        else if (op == 4'b0001)     d = C3_LDIND;
        else                        d = (ILLEGAL_TRAP != 0) ? S_FAULT : S_RESET;
        return d;
    endfunction

    assign state         = state_r;
    assign fault         = (state_r == S_FAULT);
    assign mem_wait      = is_mem_s & ~mem_ready;
    assign retired_count = retired_r;

    // Memory-state classification and bus-timeout detection.
    always_comb begin
        is_mem_s  = (state_r == C1) || (state_r == C3_LOAD) || (state_r == C3_STORE) ||
                    (state_r == C3_LDIND) || (state_r == C5_LDIND);
        timeout_s = (WAIT_MAX > 0) && is_mem_s && !mem_ready &&
                    (wait_r == WAIT_W'(WAIT_MAX));
    end

    // Next-state logic: natural successor, held while memory is not ready.
    always_comb begin
        succ_s = S_RESET;
        case (state_r)
            S_RESET:  succ_s = C1;
            C1:       succ_s = C2;
            C2:       succ_s = decode(instr);
            C3_ASN:   succ_s = C4_ASNSH;
            C3_SHIFT: succ_s = C4_ASNSH;
            C3_ORI:   succ_s = C4_ORI;
            C4_ORI:   succ_s = C5_ORI;
            C3_LOAD:  succ_s = C4_LOAD;
            C3_LDIND: succ_s = C4_LDIND;
            C4_LDIND: succ_s = C5_LDIND;
            C5_LDIND: succ_s = C6_LDIND;
            S_FAULT:  succ_s = S_FAULT;
            default:  succ_s = C1;
        endcase
        if (is_mem_s && !mem_ready) begin
            state_next_s = timeout_s ? S_FAULT : state_r;
        end else begin
            state_next_s = succ_s;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= S_RESET;
        else       state_r <= state_next_s;
    end

    // Consecutive not-ready counter; restarts whenever the state changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             wait_r <= '0;
        else if (state_next_s != state_r)      wait_r <= '0;
        else if (is_mem_s && !mem_ready)       wait_r <= wait_r + WAIT_W'(1);
        else                                   wait_r <= '0;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           retired_r <= '0;
        else if (instr_done) retired_r <= retired_r + CNT_W'(1);
        else                 retired_r <= retired_r;
    end

    // Control bus decode; register-commit strobes in memory states wait for mem_ready.
    always_comb begin
        PCwrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRload = 1'b0;
        OpASel = 1'b0; MDRload = 1'b0; OpABLoad = 1'b0; ALU1 = 1'b0;
        ALUOutWrite = 1'b0; RFWrite = 1'b0; RegIn = 1'b0; FlagWrite = 1'b0;
        AddrSel = 2'b00; ALU2 = 3'b000; ALUop = 3'b000; instr_done = 1'b0;
        case (state_r)
            C1: begin
                PCwrite = mem_ready; AddrSel = 2'b01; MemRead = 1'b1;
                IRload = mem_ready; ALU2 = 3'b001;
            end
            C2: OpABLoad = 1'b1;
            C3_ASN: begin
                ALU1 = 1'b1; ALUOutWrite = 1'b1; FlagWrite = 1'b1;
                case (instr)
                    4'b0110: ALUop = 3'b001;
                    4'b1000: ALUop = 3'b011;
                    default: ALUop = 3'b000;
                endcase
            end
            C3_SHIFT: begin
                ALU1 = 1'b1; ALU2 = 3'b100; ALUop = 3'b100;
                ALUOutWrite = 1'b1; FlagWrite = 1'b1;
            end
            C4_ASNSH: begin RFWrite = 1'b1; instr_done = 1'b1; end
            C3_ORI:   begin OpASel = 1'b1; OpABLoad = 1'b1; end
            C4_ORI: begin
                ALU1 = 1'b1; ALU2 = 3'b011; ALUop = 3'b010;
                ALUOutWrite = 1'b1; FlagWrite = 1'b1;
            end
            C5_ORI:   begin OpASel = 1'b1; RFWrite = 1'b1; instr_done = 1'b1; end
            C3_LOAD, C3_LDIND: begin
                AddrSel = 2'b00; MemRead = 1'b1; MDRload = mem_ready;
            end
            C4_LOAD: begin
                ALUOutWrite = 1'b1; RFWrite = 1'b1; RegIn = 1'b1; instr_done = 1'b1;
            end
            C3_STORE: begin MemWrite = 1'b1; instr_done = mem_ready; end
            C3_BPZ:   begin ALU2 = 3'b010; PCwrite = ~N; instr_done = 1'b1; end
            C3_BZ:    begin ALU2 = 3'b010; PCwrite = Z;  instr_done = 1'b1; end
            C3_BNZ:   begin ALU2 = 3'b010; PCwrite = ~Z; instr_done = 1'b1; end
            C4_LDIND: begin OpABLoad = 1'b1; RFWrite = 1'b1; RegIn = 1'b1; end
            C5_LDIND: begin
                AddrSel = 2'b10; MemRead = 1'b1; MDRload = mem_ready;
            end
            C6_LDIND: begin
                AddrSel = 2'b10; OpABLoad = 1'b1; RFWrite = 1'b1; RegIn = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                PCwrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: d0 uses default parameters,
// d1 uses WAIT_MAX=3, CNT_W=4 and the illegal-opcode trap.
module tb_multicycle_ctrl_fsm;

    logic clock = 1'b0;
    logic reset;
    logic [3:0] instr;
    logic N, Z, mem_ready;

    logic pcw0, mr0, mw0, irl0, oas0, mdr0, oab0, a10, aow0, rfw0, rin0, fw0;
    logic [1:0] as0; logic [2:0] a20, op0; logic [4:0] st0;
    logic wt0, dn0, ft0; logic [15:0] rc0;
    logic pcw1, mr1, mw1, irl1, oas1, mdr1, oab1, a11, aow1, rfw1, rin1, fw1;
    logic [1:0] as1; logic [2:0] a21, op1; logic [4:0] st1;
    logic wt1, dn1, ft1; logic [3:0] rc1;
    logic [19:0] c0, c1;

    assign c0 = {pcw0, mr0, mw0, irl0, oas0, mdr0, oab0, a10, aow0, rfw0, rin0, fw0, as0, a20, op0};
    assign c1 = {pcw1, mr1, mw1, irl1, oas1, mdr1, oab1, a11, aow1, rfw1, rin1, fw1, as1, a21, op1};

    multicycle_ctrl_fsm d0 (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
        .PCwrite(pcw0), .MemRead(mr0), .MemWrite(mw0), .IRload(irl0), .OpASel(oas0),
        .MDRload(mdr0), .OpABLoad(oab0), .ALU1(a10), .ALUOutWrite(aow0), .RFWrite(rfw0),
        .RegIn(rin0), .FlagWrite(fw0), .AddrSel(as0), .ALU2(a20), .ALUop(op0),
        .state(st0), .mem_wait(wt0), .instr_done(dn0), .fault(ft0), .retired_count(rc0)
    );

    multicycle_ctrl_fsm #(.WAIT_MAX(3), .WAIT_W(4), .CNT_W(4), .ILLEGAL_TRAP(1)) d1 (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
        .PCwrite(pcw1), .MemRead(mr1), .MemWrite(mw1), .IRload(irl1), .OpASel(oas1),
        .MDRload(mdr1), .OpABLoad(oab1), .ALU1(a11), .ALUOutWrite(aow1), .RFWrite(rfw1),
        .RegIn(rin1), .FlagWrite(fw1), .AddrSel(as1), .ALU2(a21), .ALUop(op1),
        .state(st1), .mem_wait(wt1), .instr_done(dn1), .fault(ft1), .retired_count(rc1)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          sel;
        logic [4:0]  st;
        logic [19:0] ctrl;
        logic        mw;
        logic        done;
        logic        flt;
        logic [15:0] ret;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_ret;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_mem(input logic [4:0] st);
        return (st == 5'd1) || (st == 5'd9) || (st == 5'd11) || (st == 5'd15) || (st == 5'd17);
    endfunction

    // Expected control bus for a state, straight from the per-state output table.
    function automatic logic [19:0] ctrl_of(input logic [4:0] st, input logic rdy, n, z,
                                            input logic [3:0] ins);
        logic pcw, mr, mw, irl, oas, mdr, oab, a1, aow, rfw, rin, fw;
        logic [1:0] as; logic [2:0] a2, op;
        {pcw, mr, mw, irl, oas, mdr, oab, a1, aow, rfw, rin, fw} = 12'b0;
        as = 2'b00; a2 = 3'b000; op = 3'b000;
        case (st)
            5'd1:  begin pcw = rdy; as = 2'b01; mr = 1'b1; irl = rdy; a2 = 3'b001; end
            5'd2:  oab = 1'b1;
            5'd3:  begin a1 = 1'b1; aow = 1'b1; fw = 1'b1;
                         op = (ins == 4'b0110) ? 3'b001 : (ins == 4'b1000) ? 3'b011 : 3'b000; end
            5'd4:  rfw = 1'b1;
            5'd5:  begin a1 = 1'b1; a2 = 3'b100; op = 3'b100; aow = 1'b1; fw = 1'b1; end
            5'd6:  begin oas = 1'b1; oab = 1'b1; end
            5'd7:  begin a1 = 1'b1; a2 = 3'b011; op = 3'b010; aow = 1'b1; fw = 1'b1; end
            5'd8:  begin oas = 1'b1; rfw = 1'b1; end
            5'd9, 5'd15: begin mr = 1'b1; mdr = rdy; end
            5'd10: begin aow = 1'b1; rfw = 1'b1; rin = 1'b1; end
            5'd11: mw = 1'b1;
            5'd12: begin a2 = 3'b010; pcw = ~n; end
            5'd13: begin a2 = 3'b010; pcw = z; end
            5'd14: begin a2 = 3'b010; pcw = ~z; end
            5'd16: begin oab = 1'b1; rfw = 1'b1; rin = 1'b1; end
            5'd17: begin as = 2'b10; mr = 1'b1; mdr = rdy; end
            5'd18: begin as = 2'b10; oab = 1'b1; rfw = 1'b1; rin = 1'b1; end
            default: ;
        endcase
        return {pcw, mr, mw, irl, oas, mdr, oab, a1, aow, rfw, rin, fw, as, a2, op};
    endfunction

    // Monitor: compare every queued expectation against the selected DUT on the falling edge.
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            if (mon_e.sel == 0) begin
                check_val("state", {27'b0, st0}, {27'b0, mon_e.st});
                check_val("ctrl",  {12'b0, c0},  {12'b0, mon_e.ctrl});
                check_val("mem_wait", {31'b0, wt0}, {31'b0, mon_e.mw});
                check_val("instr_done", {31'b0, dn0}, {31'b0, mon_e.done});
                check_val("fault", {31'b0, ft0}, {31'b0, mon_e.flt});
                check_val("retired", {16'b0, rc0}, {16'b0, mon_e.ret});
            end else begin
                check_val("state1", {27'b0, st1}, {27'b0, mon_e.st});
                check_val("ctrl1",  {12'b0, c1},  {12'b0, mon_e.ctrl});
                check_val("mem_wait1", {31'b0, wt1}, {31'b0, mon_e.mw});
                check_val("instr_done1", {31'b0, dn1}, {31'b0, mon_e.done});
                check_val("fault1", {31'b0, ft1}, {31'b0, mon_e.flt});
                check_val("retired1", {28'b0, rc1}, {28'b0, mon_e.ret[3:0]});
            end
        end
    end

    // One clock cycle: drive mem_ready, queue the expectation, advance past the edge.
    task automatic cyc(input int sel, input logic rdy, input logic [4:0] est, input logic edone);
        exp_t e;
        mem_ready = rdy;
        e.sel  = sel;
        e.st   = est;
        e.ctrl = ctrl_of(est, rdy, N, Z, instr);
        e.mw   = is_mem(est) && !rdy;
        e.done = edone;
        e.flt  = (est == 5'd31);
        e.ret  = exp_ret;
        sbq.push_back(e);
        @(posedge clock); #1;
        if (edone) exp_ret = exp_ret + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        exp_ret = 16'd0;
    endtask

    // Full instruction with memory always ready: C1, C2, then the listed states.
    task automatic run_instr(input int sel, input logic [3:0] ins, input logic n, input logic z,
                             input logic [19:0] seq, input int len);
        instr = ins; N = n; Z = z;
        cyc(sel, 1'b1, 5'd1, 1'b0);
        cyc(sel, 1'b1, 5'd2, 1'b0);
        for (int k = 0; k < len; k++) cyc(sel, 1'b1, seq[5*k +: 5], (k == len - 1));
    endtask

    initial begin
        instr = 4'b0100; N = 1'b0; Z = 1'b0; mem_ready = 1'b1; reset = 1'b1; exp_ret = 16'd0;
        do_reset();
        cyc(0, 1'b1, 5'd0, 1'b0);

        // ALU, shift, immediate, load/store and branch instructions, memory always ready.
        run_instr(0, 4'b0100, 1'b0, 1'b0, {10'd0, 5'd4, 5'd3}, 2);
        run_instr(0, 4'b0110, 1'b0, 1'b0, {10'd0, 5'd4, 5'd3}, 2);
        run_instr(0, 4'b1000, 1'b0, 1'b0, {10'd0, 5'd4, 5'd3}, 2);
        run_instr(0, 4'b1011, 1'b0, 1'b0, {10'd0, 5'd4, 5'd5}, 2);
        run_instr(0, 4'b0111, 1'b0, 1'b0, {5'd0, 5'd8, 5'd7, 5'd6}, 3);
        run_instr(0, 4'b0000, 1'b0, 1'b0, {10'd0, 5'd10, 5'd9}, 2);
        run_instr(0, 4'b0010, 1'b0, 1'b0, {15'd0, 5'd11}, 1);
        run_instr(0, 4'b1101, 1'b0, 1'b0, {15'd0, 5'd12}, 1);
        run_instr(0, 4'b1101, 1'b1, 1'b0, {15'd0, 5'd12}, 1);
        run_instr(0, 4'b1001, 1'b0, 1'b0, {15'd0, 5'd14}, 1);
        run_instr(0, 4'b1001, 1'b0, 1'b1, {15'd0, 5'd14}, 1);

        // LDIND with three not-ready cycles in C3_LDIND.
        instr = 4'b0001;
        cyc(0, 1'b1, 5'd1, 1'b0); cyc(0, 1'b1, 5'd2, 1'b0);
        repeat (3) cyc(0, 1'b0, 5'd15, 1'b0);
        cyc(0, 1'b1, 5'd15, 1'b0); cyc(0, 1'b1, 5'd16, 1'b0);
        cyc(0, 1'b0, 5'd17, 1'b0); cyc(0, 1'b1, 5'd17, 1'b0); cyc(0, 1'b1, 5'd18, 1'b1);

        // STORE completes only on the ready cycle.
        instr = 4'b0010;
        cyc(0, 1'b1, 5'd1, 1'b0); cyc(0, 1'b1, 5'd2, 1'b0);
        cyc(0, 1'b0, 5'd11, 1'b0); cyc(0, 1'b1, 5'd11, 1'b1);

        // BZ not taken, then taken.
        run_instr(0, 4'b0101, 1'b0, 1'b0, {15'd0, 5'd13}, 1);
        run_instr(0, 4'b0101, 1'b0, 1'b1, {15'd0, 5'd13}, 1);
        cyc(0, 1'b1, 5'd1, 1'b0);

        // Timeout: WAIT_MAX=3, memory stuck in C1 -> fault after 4 wait cycles, absorbing.
        do_reset();
        cyc(1, 1'b1, 5'd0, 1'b0);
        instr = 4'b0100;
        repeat (4) cyc(1, 1'b0, 5'd1, 1'b0);
        cyc(1, 1'b0, 5'd31, 1'b0); cyc(1, 1'b1, 5'd31, 1'b0); cyc(1, 1'b1, 5'd31, 1'b0);

        // Ready on the last allowed wait cycle wins; counter restarts in the next memory state.
        do_reset();
        cyc(1, 1'b1, 5'd0, 1'b0);
        instr = 4'b0000;
        repeat (3) cyc(1, 1'b0, 5'd1, 1'b0);
        cyc(1, 1'b1, 5'd1, 1'b0); cyc(1, 1'b1, 5'd2, 1'b0);
        repeat (3) cyc(1, 1'b0, 5'd9, 1'b0);
        cyc(1, 1'b1, 5'd9, 1'b0); cyc(1, 1'b1, 5'd10, 1'b1); cyc(1, 1'b1, 5'd1, 1'b0);

        // Illegal opcode: trap on d1, back to S_RESET on d0.
        do_reset();
        cyc(1, 1'b1, 5'd0, 1'b0);
        instr = 4'b1010;
        cyc(1, 1'b1, 5'd1, 1'b0); cyc(1, 1'b1, 5'd2, 1'b0);
        cyc(1, 1'b1, 5'd31, 1'b0); cyc(1, 1'b1, 5'd31, 1'b0);
        do_reset();
        cyc(0, 1'b1, 5'd0, 1'b0);
        cyc(0, 1'b1, 5'd1, 1'b0); cyc(0, 1'b1, 5'd2, 1'b0);
        cyc(0, 1'b1, 5'd0, 1'b0); cyc(0, 1'b1, 5'd1, 1'b0);

        // Asynchronous reset in C5_ORI.
        do_reset();
        cyc(0, 1'b1, 5'd0, 1'b0);
        instr = 4'b0111;
        cyc(0, 1'b1, 5'd1, 1'b0); cyc(0, 1'b1, 5'd2, 1'b0);
        cyc(0, 1'b1, 5'd6, 1'b0); cyc(0, 1'b1, 5'd7, 1'b0);
        #2;
        check_val("pre_reset_state", {27'b0, st0}, 32'd8);
        reset = 1'b1;
        #1;
        check_val("async_reset_state", {27'b0, st0}, 32'd0);
        check_val("async_reset_ctrl", {12'b0, c0}, 32'd0);
        check_val("async_reset_done", {31'b0, dn0}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_ret = 16'd0;
        cyc(0, 1'b1, 5'd0, 1'b0);

        // Retired counter wrap on the 4-bit instance.
        do_reset();
        cyc(1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) run_instr(1, 4'b0101, 1'b0, 1'b1, {15'd0, 5'd13}, 1);
        check_val("wrap_cnt4", {28'b0, rc1}, 32'd0);
        check_val("nowrap_cnt16", {16'b0, rc0}, 32'd16);
        cyc(1, 1'b1, 5'd1, 1'b0);

        @(negedge clock); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
